// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and bus widths, common to master and slave.
package apb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter with clear and enable.
// hit flags the enabled cycle whose increment brings the count to TIMEOUT.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic pclk,
  input  logic preset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Combinational so the abort happens on the same edge the count reaches TIMEOUT.
  assign hit = en && (count >= LIMIT);

endmodule

// File: rtl/apb_master_wait.sv
// APB master with one outstanding transfer, wait-state support and an ACCESS-phase timeout.
//
// state  | meaning
// IDLE   | cmd_ready high, bus idle, rsp pulse lands here
// SETUP  | psel high, penable low, one cycle
// ACCESS | psel and penable high until pready or timeout
module apb_master_wait
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  apb_state_t state;
  logic       timer_clr;
  logic       timer_en;
  logic       timer_hit;

  assign timer_clr = (state == SETUP);
  assign timer_en  = (state == ACCESS) && !pready;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .pclk   (pclk),
    .preset (preset),
    .clr    (timer_clr),
    .en     (timer_en),
    .hit    (timer_hit)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr     <= cmd_addr;
            pwrite    <= cmd_write;
            pwdata    <= cmd_wdata;
            psel      <= 1'b1;
            penable   <= 1'b0;
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready wins over a timeout hitting in the same cycle
          if (pready) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= pwrite ? '0 : prdata;
            state       <= IDLE;
          end else if (timer_hit) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state       <= IDLE;
          end
        end
        default: begin
          psel      <= 1'b0;
          penable   <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
